// File: rtl/lenet_frame_sched.sv
// Frame-level scheduler for the camera-to-LeNet path: picks capture frames,
// launches the CNN, latches its class result and drives the preview overlay.
module lenet_frame_sched #(
    parameter int CAPTURE_PERIOD = 8,
    parameter int SHOW_FRAMES    = 30,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int RESULT_W       = 4
) (
    input  logic                clk24,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                single_shot,
    input  logic                show_en,
    input  logic                err_clr,
    input  logic                core_end,
    input  logic                lenet_data_ready,
    input  logic                lenet_done,
    input  logic [RESULT_W-1:0] lenet_result,
    output logic                lenet_doing_signal,
    output logic                lenet_showing_signal,
    output logic                lenet_start,
    output logic [RESULT_W-1:0] result_digit,
    output logic                result_valid,
    output logic                timeout_err,
    output logic                capture_miss,
    output logic [2:0]          state_dbg
);

    localparam int FC_W = $clog2(CAPTURE_PERIOD) + 1;
    localparam int SC_W = $clog2(SHOW_FRAMES) + 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_START   = 3'd3,
        S_RUN     = 3'd4,
        S_SHOW    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [SC_W-1:0]     show_cnt_q, show_cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                pending_q, pending_d;
    logic                arm_auto_q, arm_auto_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                valid_q, valid_d;
    logic                doing_q, showing_q, start_q;
    logic                timeout_err_q, capture_miss_q;
    logic                timeout_set, miss_set;

    // Next-state logic; arm_auto remembers whether ARM may be abandoned when enable drops.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        show_cnt_d  = show_cnt_q;
        wdog_d      = wdog_q;
        pending_d   = pending_q | single_shot;
        arm_auto_d  = arm_auto_q;
        result_d    = result_q;
        valid_d     = valid_q;
        timeout_set = 1'b0;
        miss_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_end) begin
                    if (pending_q || single_shot) begin
                        state_d     = S_ARM;
                        arm_auto_d  = 1'b0;
                        frame_cnt_d = '0;
                    end else if (enable && frame_cnt_q == FC_W'(CAPTURE_PERIOD - 1)) begin
                        state_d     = S_ARM;
                        arm_auto_d  = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end
            end
            S_ARM: begin
                if (core_end) begin
                    state_d = S_CAPTURE;
                end else if (arm_auto_q && !enable) begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (lenet_data_ready) begin
                    state_d = S_START;
                end else if (core_end) begin
                    state_d  = S_IDLE;
                    miss_set = 1'b1;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (lenet_done) begin
                    result_d   = lenet_result;
                    valid_d    = 1'b1;
                    show_cnt_d = '0;
                    state_d    = S_SHOW;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_SHOW: begin
                if (core_end) begin
                    if (show_cnt_q == SC_W'(SHOW_FRAMES - 1)) begin
                        show_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        show_cnt_d = show_cnt_q + SC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_ARM && state_d == S_ARM) begin
            pending_d = 1'b0;
        end
    end

    // Outputs are registered from the next state so the core sees clean levels.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            show_cnt_q     <= '0;
            wdog_q         <= '0;
            pending_q      <= 1'b0;
            arm_auto_q     <= 1'b0;
            result_q       <= '0;
            valid_q        <= 1'b0;
            doing_q        <= 1'b0;
            showing_q      <= 1'b0;
            start_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
            capture_miss_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            show_cnt_q     <= show_cnt_d;
            wdog_q         <= wdog_d;
            pending_q      <= pending_d;
            arm_auto_q     <= arm_auto_d;
            result_q       <= result_d;
            valid_q        <= valid_d;
            doing_q        <= (state_d == S_ARM);
            showing_q      <= (state_d == S_SHOW) && show_en;
            start_q        <= (state_d == S_START);
            timeout_err_q  <= timeout_set | (timeout_err_q & ~err_clr);
            capture_miss_q <= miss_set | (capture_miss_q & ~err_clr);
        end
    end

    assign lenet_doing_signal   = doing_q;
    assign lenet_showing_signal = showing_q;
    assign lenet_start          = start_q;
    assign result_digit         = result_q;
    assign result_valid         = valid_q;
    assign timeout_err          = timeout_err_q;
    assign capture_miss         = capture_miss_q;
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_lenet_frame_sched.sv
// Scenario bench for lenet_frame_sched: randomized frame gaps, CNN latencies
// and class results, with expectations derived from the scheduling rules.
module tb_lenet_frame_sched;

    localparam int CP = 2;
    localparam int SF = 3;
    localparam int TO = 16;
    localparam int RW = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_SHOW    = 3'd5;

    logic          clk24 = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0, single_shot = 1'b0, show_en = 1'b0, err_clr = 1'b0;
    logic          core_end = 1'b0, lenet_data_ready = 1'b0, lenet_done = 1'b0;
    logic [RW-1:0] lenet_result = '0;
    logic          doing, showing, lenet_start, result_valid, timeout_err, capture_miss;
    logic [RW-1:0] result_digit;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    lenet_frame_sched #(
        .CAPTURE_PERIOD(CP), .SHOW_FRAMES(SF), .TIMEOUT_CYCLES(TO), .RESULT_W(RW)
    ) dut (
        .clk24(clk24), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
        .show_en(show_en), .err_clr(err_clr), .core_end(core_end),
        .lenet_data_ready(lenet_data_ready), .lenet_done(lenet_done),
        .lenet_result(lenet_result), .lenet_doing_signal(doing),
        .lenet_showing_signal(showing), .lenet_start(lenet_start),
        .result_digit(result_digit), .result_valid(result_valid),
        .timeout_err(timeout_err), .capture_miss(capture_miss), .state_dbg(state_dbg)
    );

    always #5 clk24 = ~clk24;

    task automatic tick();
        @(posedge clk24);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_core_end();
        core_end = 1'b1; tick(); core_end = 1'b0;
    endtask

    task automatic pulse_data_ready();
        lenet_data_ready = 1'b1; tick(); lenet_data_ready = 1'b0;
    endtask

    task automatic pulse_single_shot();
        single_shot = 1'b1; tick(); single_shot = 1'b0;
    endtask

    task automatic pulse_done(input logic [RW-1:0] r);
        lenet_result = r; lenet_done = 1'b1; tick(); lenet_done = 1'b0;
    endtask

    task automatic do_reset();
        enable = 0; single_shot = 0; show_en = 0; err_clr = 0;
        core_end = 0; lenet_data_ready = 0; lenet_done = 0; lenet_result = '0;
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
        end
        checks++;
        if ({doing, showing, lenet_start, result_digit, result_valid, timeout_err, capture_miss} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0",
                     {doing, showing, lenet_start, result_digit, result_valid, timeout_err, capture_miss});
        end
    endtask

    // Periodic capture through a full classification; first pass uses the
    // latest possible done (coincident with watchdog expiry).
    task automatic test_auto_capture();
        for (int it = 0; it < 4; it++) begin
            int gap, d;
            logic [RW-1:0] r;
            logic se;
            gap = $urandom_range(2, 6);
            d   = (it == 0) ? TO - 1 : $urandom_range(0, TO - 2);
            r   = RW'($urandom_range(0, 15));
            se  = it[0];
            do_reset();
            enable = 1'b1; show_en = se;
            for (int f = 1; f <= CP; f++) begin
                wait_cycles(gap);
                pulse_core_end();
                checks++;
                if (state_dbg !== ((f == CP) ? ST_ARM : ST_IDLE) || doing !== (f == CP)) begin
                    errors++;
                    $display("[TB] FAIL auto_arm f=%0d: state=%0d doing=%0b expected state=%0d doing=%0b",
                             f, state_dbg, doing, (f == CP) ? ST_ARM : ST_IDLE, f == CP);
                end
            end
            wait_cycles(gap);
            checks++;
            if (state_dbg !== ST_ARM || doing !== 1'b1) begin
                errors++; $display("[TB] FAIL arm_hold: state=%0d doing=%0b expected 1/1", state_dbg, doing);
            end
            pulse_core_end();
            checks++;
            if (state_dbg !== ST_CAPTURE || doing !== 1'b0) begin
                errors++; $display("[TB] FAIL capture_entry: state=%0d doing=%0b expected 2/0", state_dbg, doing);
            end
            wait_cycles(gap);
            pulse_data_ready();
            checks++;
            if (state_dbg !== ST_START || lenet_start !== 1'b1) begin
                errors++; $display("[TB] FAIL start_pulse: state=%0d start=%0b expected 3/1", state_dbg, lenet_start);
            end
            tick();
            checks++;
            if (state_dbg !== ST_RUN || lenet_start !== 1'b0) begin
                errors++; $display("[TB] FAIL run_entry: state=%0d start=%0b expected 4/0", state_dbg, lenet_start);
            end
            enable = 1'b0;
            wait_cycles(d);
            pulse_done(r);
            checks++;
            if (state_dbg !== ST_SHOW || result_digit !== r || result_valid !== 1'b1 ||
                showing !== se || timeout_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL result_latch d=%0d: state=%0d digit=%0d valid=%0b show=%0b tmo=%0b expected 5/%0d/1/%0b/0",
                         d, state_dbg, result_digit, result_valid, showing, timeout_err, r, se);
            end
            for (int f = 1; f <= SF; f++) begin
                wait_cycles(gap);
                pulse_core_end();
                checks++;
                if (state_dbg !== ((f < SF) ? ST_SHOW : ST_IDLE) || showing !== ((f < SF) ? se : 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL show_frames f=%0d: state=%0d showing=%0b", f, state_dbg, showing);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pulse_single_shot();
        pulse_core_end();
        pulse_core_end();
        pulse_data_ready();
        tick();
        wait_cycles(TO - 1);
        checks++;
        if (state_dbg !== ST_RUN || timeout_err !== 1'b0) begin
            errors++; $display("[TB] FAIL wdog_early: state=%0d tmo=%0b expected 4/0", state_dbg, timeout_err);
        end
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || timeout_err !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wdog_expire: state=%0d tmo=%0b valid=%0b expected 0/1/0",
                     state_dbg, timeout_err, result_valid);
        end
        wait_cycles($urandom_range(1, 5));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("[TB] FAIL tmo_clear: got %0b expected 0", timeout_err);
        end
    endtask

    task automatic test_single_shot();
        logic [RW-1:0] r;
        int gap;
        r = RW'($urandom_range(1, 15));
        gap = $urandom_range(2, 6);
        do_reset();
        show_en = 1'b1;
        wait_cycles(gap);
        single_shot = 1'b1; core_end = 1'b1; tick(); single_shot = 1'b0; core_end = 1'b0;
        checks++;
        if (state_dbg !== ST_ARM || doing !== 1'b1) begin
            errors++; $display("[TB] FAIL shot_coincident: state=%0d doing=%0b expected 1/1", state_dbg, doing);
        end
        wait_cycles(gap);
        checks++;
        if (state_dbg !== ST_ARM) begin
            errors++; $display("[TB] FAIL shot_arm_hold: state=%0d expected 1", state_dbg);
        end
        pulse_core_end();
        pulse_data_ready();
        tick();
        wait_cycles(2);
        pulse_single_shot();
        wait_cycles(2);
        pulse_done(r);
        for (int f = 1; f <= SF; f++) begin
            wait_cycles(gap);
            pulse_core_end();
        end
        wait_cycles(gap);
        checks++;
        if (state_dbg !== ST_IDLE || result_digit !== r || showing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shot_show_end: state=%0d digit=%0d showing=%0b expected 0/%0d/0",
                     state_dbg, result_digit, showing, r);
        end
        pulse_core_end();
        checks++;
        if (state_dbg !== ST_ARM) begin
            errors++; $display("[TB] FAIL shot_requeued: state=%0d expected 1", state_dbg);
        end
        pulse_core_end();
        pulse_core_end();
        pulse_core_end();
        checks++;
        if (state_dbg !== ST_IDLE || capture_miss !== 1'b1) begin
            errors++; $display("[TB] FAIL shot_absorbed: state=%0d miss=%0b expected 0/1", state_dbg, capture_miss);
        end
    endtask

    task automatic test_capture_miss();
        do_reset();
        enable = 1'b1;
        for (int f = 0; f < CP + 1; f++) pulse_core_end();
        wait_cycles($urandom_range(1, 8));
        pulse_core_end();
        checks++;
        if (state_dbg !== ST_IDLE || capture_miss !== 1'b1 || lenet_start !== 1'b0) begin
            errors++; $display("[TB] FAIL miss_set: state=%0d miss=%0b expected 0/1", state_dbg, capture_miss);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++;
        if (capture_miss !== 1'b0) begin
            errors++; $display("[TB] FAIL miss_clear: got %0b expected 0", capture_miss);
        end
        for (int f = 0; f < CP; f++) pulse_core_end();
        enable = 1'b0;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || doing !== 1'b0) begin
            errors++; $display("[TB] FAIL auto_arm_abort: state=%0d doing=%0b expected 0/0", state_dbg, doing);
        end
        enable = 1'b1;
        for (int f = 0; f < CP + 1; f++) pulse_core_end();
        core_end = 1'b1; err_clr = 1'b1; tick(); core_end = 1'b0; err_clr = 1'b0;
        checks++;
        if (capture_miss !== 1'b1) begin
            errors++; $display("[TB] FAIL miss_set_wins: got %0b expected 1", capture_miss);
        end
    endtask

    task automatic test_reset_in_run();
        logic [RW-1:0] r;
        r = RW'($urandom_range(1, 15));
        do_reset();
        show_en = 1'b1;
        pulse_single_shot();
        pulse_core_end();
        pulse_core_end();
        pulse_data_ready();
        tick();
        pulse_single_shot();
        pulse_done(r);
        for (int f = 0; f < SF; f++) pulse_core_end();
        pulse_core_end();
        pulse_core_end();
        pulse_data_ready();
        tick();
        checks++;
        if (state_dbg !== ST_RUN || result_valid !== 1'b1 || result_digit !== r) begin
            errors++;
            $display("[TB] FAIL second_run: state=%0d valid=%0b digit=%0d expected 4/1/%0d",
                     state_dbg, result_valid, result_digit, r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state_dbg, doing, showing, lenet_start, result_digit, result_valid, timeout_err, capture_miss} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b expected 0",
                     {state_dbg, doing, showing, lenet_start, result_digit, result_valid, timeout_err, capture_miss});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_auto_capture();
        test_timeout();
        test_single_shot();
        test_capture_miss();
        test_reset_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
